// File: rtl/long_op_scheduler_if.sv
// Core <-> long-op scheduler signal bundle: ID hazard inputs, EX issue, unit handshake, write port.
// Bypass ports exist only when LONG_OP_BYPASS_EN is defined.
interface long_op_scheduler_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rs3;
  logic [2:0]  id_rs_fp;
  logic [2:0]  id_rs_valid;
  logic [4:0]  id_rd;
  logic        id_rd_fp;
  logic        id_rd_valid;
  logic        id_long_op;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_fp;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [31:0] issue_c;
  logic        unit_done;
  logic [31:0] unit_result;
  logic        pipe_wb_busy;
  logic        unit_start;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic [31:0] unit_c;
  logic        sched_stall;
  logic        sched_pipe_hold;
  logic        sched_wb_en;
  logic        sched_wb_fp;
  logic [4:0]  sched_wb_addr;
  logic [31:0] sched_wb_data;
`ifdef LONG_OP_BYPASS_EN
  logic [2:0]  bypass_hit;
  logic [31:0] bypass_data;
`endif

  modport master (
`ifdef LONG_OP_BYPASS_EN
    input  bypass_hit, bypass_data,
`endif
    output id_rs1, id_rs2, id_rs3, id_rs_fp, id_rs_valid, id_rd, id_rd_fp, id_rd_valid,
    output id_long_op, issue_valid, issue_rd, issue_fp, issue_a, issue_b, issue_c,
    output unit_done, unit_result, pipe_wb_busy,
    input  unit_start, unit_a, unit_b, unit_c, sched_stall, sched_pipe_hold,
    input  sched_wb_en, sched_wb_fp, sched_wb_addr, sched_wb_data
  );

  modport slave (
`ifdef LONG_OP_BYPASS_EN
    output bypass_hit, bypass_data,
`endif
    input  id_rs1, id_rs2, id_rs3, id_rs_fp, id_rs_valid, id_rd, id_rd_fp, id_rd_valid,
    input  id_long_op, issue_valid, issue_rd, issue_fp, issue_a, issue_b, issue_c,
    input  unit_done, unit_result, pipe_wb_busy,
    output unit_start, unit_a, unit_b, unit_c, sched_stall, sched_pipe_hold,
    output sched_wb_en, sched_wb_fp, sched_wb_addr, sched_wb_data
  );
endinterface

// File: rtl/long_op_scheduler.sv
// Scheduler for one shared multi-cycle unit: issue latch, pending-dest hazard stall, write-port arbitration.
// Optional macro LONG_OP_BYPASS_EN forwards the buffered result to ID sources while waiting for the port.
module long_op_scheduler #(
  parameter int HOLD_AFTER = 4
) (
  input logic                 clk,
  input logic                 rst,
  long_op_scheduler_if.slave  bus
);
  localparam int CW = $clog2(HOLD_AFTER + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_AFTER);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, WAIT_WB = 2'd2} state_t;

  state_t         state_reg, state_next;
  logic [4:0]     pend_rd_reg, pend_rd_next;
  logic           pend_fp_reg, pend_fp_next;
  logic [31:0]    a_reg, a_next;
  logic [31:0]    b_reg, b_next;
  logic [31:0]    c_reg, c_next;
  logic           start_reg, start_next;
  logic [31:0]    buf_reg, buf_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           hold_reg, hold_next;
  logic           wb_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pend_rd_reg <= 5'd0;
      pend_fp_reg <= 1'b0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      c_reg       <= 32'd0;
      start_reg   <= 1'b0;
      buf_reg     <= 32'd0;
      cnt_reg     <= '0;
      hold_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pend_rd_reg <= pend_rd_next;
      pend_fp_reg <= pend_fp_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      c_reg       <= c_next;
      start_reg   <= start_next;
      buf_reg     <= buf_next;
      cnt_reg     <= cnt_next;
      hold_reg    <= hold_next;
    end
  end

  // An int x0 destination is architecturally dead: never written, never a hazard.
  logic pend_live;
  logic issue_live;
  assign pend_live  = (pend_rd_reg != 5'd0) | pend_fp_reg;
  assign issue_live = (bus.issue_rd != 5'd0) | bus.issue_fp;

  always_comb begin
    state_next   = state_reg;
    pend_rd_next = pend_rd_reg;
    pend_fp_next = pend_fp_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    c_next       = c_reg;
    start_next   = 1'b0;
    buf_next     = buf_reg;
    cnt_next     = cnt_reg;
    hold_next    = hold_reg;
    wb_en        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.issue_valid) begin
          state_next   = BUSY;
          pend_rd_next = bus.issue_rd;
          pend_fp_next = bus.issue_fp;
          a_next       = bus.issue_a;
          b_next       = bus.issue_b;
          c_next       = bus.issue_c;
          start_next   = 1'b1;
        end
      end
      BUSY: begin
        if (bus.unit_done) begin
          buf_next   = bus.unit_result;
          state_next = WAIT_WB;
        end
      end
      WAIT_WB: begin
        if (!pend_live) begin
          state_next = IDLE;
          cnt_next   = '0;
          hold_next  = 1'b0;
        end else if (!bus.pipe_wb_busy || hold_reg) begin
          // A held cycle has the pipeline WB suppressed, so the port is ours.
          wb_en      = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
          hold_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_next == HOLD_LIM) hold_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [4:0] src_addr [3];
  logic [2:0] src_pend_hit;
  logic [2:0] src_issue_hit;
  assign src_addr[0] = bus.id_rs1;
  assign src_addr[1] = bus.id_rs2;
  assign src_addr[2] = bus.id_rs3;

  for (genvar gi = 0; gi < 3; gi++) begin : g_src
    assign src_pend_hit[gi]  = bus.id_rs_valid[gi] & pend_live &
                               (src_addr[gi] == pend_rd_reg) & (bus.id_rs_fp[gi] == pend_fp_reg);
    assign src_issue_hit[gi] = bus.id_rs_valid[gi] & issue_live &
                               (src_addr[gi] == bus.issue_rd) & (bus.id_rs_fp[gi] == bus.issue_fp);
  end

  logic raw_pend;
  logic waw_pend;
  logic waw_issue;
  logic busy;
  assign waw_pend  = bus.id_rd_valid & pend_live & (bus.id_rd == pend_rd_reg) & (bus.id_rd_fp == pend_fp_reg);
  assign waw_issue = bus.id_rd_valid & issue_live & (bus.id_rd == bus.issue_rd) & (bus.id_rd_fp == bus.issue_fp);
  assign busy      = (state_reg != IDLE);

`ifdef LONG_OP_BYPASS_EN
  logic [2:0] bypass_hit;
  assign bypass_hit      = (state_reg == WAIT_WB) ? src_pend_hit : 3'b000;
  assign bus.bypass_hit  = bypass_hit;
  assign bus.bypass_data = (|bypass_hit) ? buf_reg : 32'd0;
  assign raw_pend        = |(src_pend_hit & ~bypass_hit);
`else
  assign raw_pend        = |src_pend_hit;
`endif

  assign bus.sched_stall = (busy & (raw_pend | waw_pend))
                         | (bus.issue_valid & ((|src_issue_hit) | waw_issue))
                         | (bus.id_long_op & (busy | bus.issue_valid));

  assign bus.unit_start      = start_reg;
  assign bus.unit_a          = a_reg;
  assign bus.unit_b          = b_reg;
  assign bus.unit_c          = c_reg;
  assign bus.sched_pipe_hold = hold_reg;
  assign bus.sched_wb_en     = wb_en;
  assign bus.sched_wb_fp     = wb_en & pend_fp_reg;
  assign bus.sched_wb_addr   = wb_en ? pend_rd_reg : 5'd0;
  assign bus.sched_wb_data   = wb_en ? buf_reg : 32'd0;
endmodule
